// File: rtl/mem_stage_lsu_if.sv
// Execute-to-MEM handshake and MEM-to-write-back result bundle for mem_stage_lsu.
// master = execute-stage side, slave = the MEM stage itself.
interface mem_stage_lsu_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr_in;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        out_valid;
    logic [31:0] instr_out;
    logic [4:0]  rd_out;
    logic [31:0] result_out;
    logic        addr_err;

    modport master (
        output in_valid, instr_in, alu_result, rs2_data, rd_in,
        input  in_ready, out_valid, instr_out, rd_out, result_out, addr_err
    );

    modport slave (
        input  in_valid, instr_in, alu_result, rs2_data, rd_in,
        output in_ready, out_valid, instr_out, rd_out, result_out, addr_err
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// RISC-V MEM stage: ALU pass-through plus byte/half/word load-store unit on a local RAM.
// Optional macro MEM_LSU_MISALIGN_TRAP_EN turns misaligned accesses into errors.
module mem_stage_lsu #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0,
    parameter int AW          = $clog2(DEPTH) + 2
) (
    input  logic          clk_100MHz,
    input  logic          reset,
    mem_stage_lsu_if.slave bus,
    input  logic          init_en,
    input  logic [AW-3:0] init_addr,
    input  logic [31:0]   init_data,
    input  logic          init_we
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam bit         HAS_WAIT = (WAIT_CYCLES > 0);
    localparam logic [3:0] CNT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ready, complete, capture;

    logic [31:0] instr_q, alu_q, rs2_q;
    logic [4:0]  rd_q;

    logic [31:0] mem [DEPTH];

    logic        out_valid_q, addr_err_q;
    logic [31:0] instr_out_q, result_q;
    logic [4:0]  rd_out_q;

    // Operand view: live inputs when completing straight from IDLE, latched copy in ACCESS.
    logic [31:0] cur_instr, cur_addr, cur_rs2;
    logic [4:0]  cur_rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_load, is_store, is_mem_in;

    assign cur_instr = (state_q == ACCESS) ? instr_q : bus.instr_in;
    assign cur_addr  = (state_q == ACCESS) ? alu_q   : bus.alu_result;
    assign cur_rs2   = (state_q == ACCESS) ? rs2_q   : bus.rs2_data;
    assign cur_rd    = (state_q == ACCESS) ? rd_q    : bus.rd_in;
    assign opcode    = cur_instr[6:0];
    assign funct3    = cur_instr[14:12];
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_mem_in = (bus.instr_in[6:0] == OP_LOAD) || (bus.instr_in[6:0] == OP_STORE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk_100MHz) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready    = 1'b0;
        complete = 1'b0;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                ready = !init_en;
                if (bus.in_valid && !init_en) begin
                    if (is_mem_in && HAS_WAIT) begin
                        capture = 1'b1;
                        cnt_d   = CNT_LOAD;
                        state_d = ACCESS;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready = ready;

    // NOTE: operand capture registers carry no reset; they are only read after being written on accept.
    always_ff @(posedge clk_100MHz) begin
        if (capture) begin
            instr_q <= bus.instr_in;
            alu_q   <= bus.alu_result;
            rs2_q   <= bus.rs2_data;
            rd_q    <= bus.rd_in;
        end
    end

    // ---------------- Address decode ----------------
    logic          out_of_range, bad_funct3, misaligned, mis_err, err;
    logic [1:0]    lane;
    logic [AW-3:0] idx;

    assign out_of_range = |(cur_addr >> AW);
    assign idx          = cur_addr[AW-1:2];
    assign misaligned   = ((funct3[1:0] == 2'b01) && cur_addr[0]) ||
                          ((funct3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));

    always_comb begin
        bad_funct3 = 1'b0;
        if (is_load)
            bad_funct3 = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        else if (is_store)
            bad_funct3 = !(funct3 inside {3'b000, 3'b001, 3'b010});
    end

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    assign mis_err = misaligned;
    assign lane    = cur_addr[1:0];
`else
    assign mis_err = 1'b0;
    always_comb begin
        case (funct3[1:0])
            2'b01:   lane = {cur_addr[1], 1'b0};
            2'b10:   lane = 2'b00;
            default: lane = cur_addr[1:0];
        endcase
    end
`endif

    assign err = (is_load || is_store) && (bad_funct3 || out_of_range || mis_err);

    // ---------------- Load path ----------------
    logic [31:0] rdata, shifted, load_val;

    assign rdata   = mem[idx];
    assign shifted = rdata >> {lane, 3'b000};

    always_comb begin
        case (funct3)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = rdata;
            3'b100:  load_val = {24'd0, shifted[7:0]};
            3'b101:  load_val = {16'd0, shifted[15:0]};
            default: load_val = 32'd0;
        endcase
    end

    // ---------------- Store path ----------------
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        we;

    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                wmask = 4'b0001 << lane;
                wdata = {4{cur_rs2[7:0]}};
            end
            2'b01: begin
                wmask = 4'b0011 << lane;
                wdata = {2{cur_rs2[15:0]}};
            end
            default: begin
                wmask = 4'b1111;
                wdata = cur_rs2;
            end
        endcase
    end

    // Reset blocks the completion write so an aborted ACCESS leaves memory untouched.
    assign we = complete && is_store && !err && !reset;

    // NOTE: memory contents are intentionally not reset; the later init write overrides a same-word store.
    always_ff @(posedge clk_100MHz) begin
        for (int i = 0; i < 4; i++) begin
            if (we && wmask[i])
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
        if (init_en && init_we)
            mem[init_addr] <= init_data;
    end

    // ---------------- Output registers ----------------
    logic [31:0] result_d;

    always_comb begin
        result_d = 32'd0;
        if (opcode == OP_R || opcode == OP_I)
            result_d = cur_addr;
        else if (is_load && !err)
            result_d = load_val;
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            instr_out_q <= 32'd0;
            rd_out_q    <= 5'd0;
            result_q    <= 32'd0;
            addr_err_q  <= 1'b0;
        end else begin
            out_valid_q <= complete;
            if (complete) begin
                instr_out_q <= cur_instr;
                rd_out_q    <= is_store ? 5'd0 : cur_rd;
                result_q    <= result_d;
                addr_err_q  <= err;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.instr_out  = instr_out_q;
    assign bus.rd_out     = rd_out_q;
    assign bus.result_out = result_q;
    assign bus.addr_err   = addr_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu with DEPTH=16 and WAIT_CYCLES=3.
module tb_mem_stage_lsu;

    localparam int DEPTH = 16;
    localparam int WAITS = 3;
    localparam int AW    = $clog2(DEPTH) + 2;

    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_I     = 7'h13;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;

    logic          clk_100MHz = 1'b0;
    logic          reset      = 1'b1;
    logic          init_en    = 1'b0;
    logic [AW-3:0] init_addr  = '0;
    logic [31:0]   init_data  = '0;
    logic          init_we    = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;

    mem_stage_lsu_if bus ();

    mem_stage_lsu #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITS)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .bus        (bus),
        .init_en    (init_en),
        .init_addr  (init_addr),
        .init_data  (init_data),
        .init_we    (init_we)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
        return {17'd0, f3, 5'd0, op};
    endfunction

    task automatic init_word(input logic [AW-3:0] a, input logic [31:0] d);
        @(negedge clk_100MHz);
        init_en = 1'b1; init_we = 1'b1; init_addr = a; init_data = d;
        @(posedge clk_100MHz); #1;
        init_en = 1'b0; init_we = 1'b0;
    endtask

    // Issues one instruction, returns edges from accept to out_valid and samples with in_ready low.
    task automatic run_op(input logic [31:0] instr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] rd, output int lat, output int busy,
                          output logic [31:0] res, output logic [4:0] rdo, output logic err);
        int n;
        @(negedge clk_100MHz);
        bus.instr_in = instr; bus.alu_result = addr; bus.rs2_data = data; bus.rd_in = rd;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk_100MHz);
            n++;
        end
        @(posedge clk_100MHz); #1;
        bus.in_valid = 1'b0;
        lat  = 1;
        busy = 0;
        while (!bus.out_valid && lat < 40) begin
            if (!bus.in_ready) busy++;
            @(posedge clk_100MHz); #1;
            lat++;
        end
        if (!bus.in_ready) busy++;
        res = bus.result_out;
        rdo = bus.rd_out;
        err = bus.addr_err;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk_100MHz);
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.result_out !== 32'd0) begin n_fails++; $display("FAIL reset_result: got %h want 0", bus.result_out); end
        n_checks++; if (bus.rd_out !== 5'd0) begin n_fails++; $display("FAIL reset_rd: got %0d want 0", bus.rd_out); end
        n_checks++; if (bus.instr_out !== 32'd0) begin n_fails++; $display("FAIL reset_instr: got %h want 0", bus.instr_out); end
        n_checks++; if (bus.addr_err !== 1'b0) begin n_fails++; $display("FAIL reset_addr_err: got %b want 0", bus.addr_err); end
        reset = 1'b0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_alu;
        int lat, busy; logic [31:0] res; logic [4:0] rdo; logic err;
        run_op(mk(3'd0, OP_R), 32'h1234, 32'h0, 5'd5, lat, busy, res, rdo, err);
        n_checks++; if (lat !== 1) begin n_fails++; $display("FAIL rtype_latency: got %0d want 1", lat); end
        n_checks++; if (res !== 32'h1234) begin n_fails++; $display("FAIL rtype_result: got %h want 00001234", res); end
        n_checks++; if (rdo !== 5'd5) begin n_fails++; $display("FAIL rtype_rd: got %0d want 5", rdo); end
        n_checks++; if (busy !== 0) begin n_fails++; $display("FAIL rtype_in_ready: low for %0d want 0", busy); end
        n_checks++; if (bus.instr_out !== mk(3'd0, OP_R)) begin n_fails++; $display("FAIL rtype_instr: got %h want %h", bus.instr_out, mk(3'd0, OP_R)); end
        @(posedge clk_100MHz); #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL rtype_pulse: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.result_out !== 32'h1234) begin n_fails++; $display("FAIL rtype_hold: got %h want 00001234", bus.result_out); end
        run_op(mk(3'd0, OP_I), 32'hDEADBEEF, 32'h0, 5'd9, lat, busy, res, rdo, err);
        n_checks++; if (res !== 32'hDEADBEEF) begin n_fails++; $display("FAIL itype_result: got %h want deadbeef", res); end
        run_op(mk(3'd0, 7'h37), 32'h55555555, 32'h0, 5'd3, lat, busy, res, rdo, err);
        n_checks++; if (lat !== 1 || res !== 32'd0 || rdo !== 5'd3) begin n_fails++; $display("FAIL other_op: lat %0d res %h rd %0d want 1 0 3", lat, res, rdo); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk_100MHz);
        bus.instr_in = mk(3'd0, OP_R); bus.alu_result = 32'hA; bus.rd_in = 5'd1; bus.in_valid = 1'b1;
        @(posedge clk_100MHz); #1;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.result_out !== 32'hA) begin n_fails++; $display("FAIL b2b_first: valid %b res %h want 1 0000000a", bus.out_valid, bus.result_out); end
        bus.alu_result = 32'hB; bus.rd_in = 5'd2;
        @(posedge clk_100MHz); #1;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.result_out !== 32'hB) begin n_fails++; $display("FAIL b2b_second: valid %b res %h want 1 0000000b", bus.out_valid, bus.result_out); end
        n_checks++; if (bus.rd_out !== 5'd2) begin n_fails++; $display("FAIL b2b_rd: got %0d want 2", bus.rd_out); end
        @(posedge clk_100MHz); #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL b2b_drop: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_loads;
        int lat, busy; logic [31:0] res; logic [4:0] rdo; logic err;
        init_word(4'd2, 32'h8070F0A5);
        run_op(mk(3'b000, OP_LOAD), 32'd8, 32'h0, 5'd4, lat, busy, res, rdo, err);
        n_checks++; if (res !== 32'hFFFFFFA5) begin n_fails++; $display("FAIL lb: got %h want ffffffa5", res); end
        n_checks++; if (lat !== 4) begin n_fails++; $display("FAIL load_latency: got %0d want 4", lat); end
        n_checks++; if (busy !== 3) begin n_fails++; $display("FAIL load_in_ready_low: got %0d want 3", busy); end
        n_checks++; if (rdo !== 5'd4 || err !== 1'b0) begin n_fails++; $display("FAIL lb_rd_err: rd %0d err %b want 4 0", rdo, err); end
        run_op(mk(3'b100, OP_LOAD), 32'd9, 32'h0, 5'd4, lat, busy, res, rdo, err);
        n_checks++; if (res !== 32'h000000F0) begin n_fails++; $display("FAIL lbu: got %h want 000000f0", res); end
        run_op(mk(3'b001, OP_LOAD), 32'd10, 32'h0, 5'd4, lat, busy, res, rdo, err);
        n_checks++; if (res !== 32'hFFFF8070) begin n_fails++; $display("FAIL lh: got %h want ffff8070", res); end
        run_op(mk(3'b101, OP_LOAD), 32'd10, 32'h0, 5'd4, lat, busy, res, rdo, err);
        n_checks++; if (res !== 32'h00008070) begin n_fails++; $display("FAIL lhu: got %h want 00008070", res); end
        run_op(mk(3'b010, OP_LOAD), 32'd8, 32'h0, 5'd4, lat, busy, res, rdo, err);
        n_checks++; if (res !== 32'h8070F0A5) begin n_fails++; $display("FAIL lw: got %h want 8070f0a5", res); end
    endtask

    task automatic test_stores;
        int lat, busy; logic [31:0] res; logic [4:0] rdo; logic err;
        run_op(mk(3'b000, OP_STORE), 32'd9, 32'hCCCCCC11, 5'd7, lat, busy, res, rdo, err);
        n_checks++; if (res !== 32'd0 || rdo !== 5'd0) begin n_fails++; $display("FAIL sb_outputs: res %h rd %0d want 0 0", res, rdo); end
        n_checks++; if (lat !== 4 || busy !== 3) begin n_fails++; $display("FAIL store_timing: lat %0d busy %0d want 4 3", lat, busy); end
        run_op(mk(3'b010, OP_LOAD), 32'd8, 32'h0, 5'd1, lat, busy, res, rdo, err);
        n_checks++; if (res !== 32'h807011A5) begin n_fails++; $display("FAIL sb_readback: got %h want 807011a5", res); end
        init_word(4'd3, 32'h00000000);
        run_op(mk(3'b001, OP_STORE), 32'd14, 32'h1234BEEF, 5'd1, lat, busy, res, rdo, err);
        run_op(mk(3'b010, OP_LOAD), 32'd12, 32'h0, 5'd1, lat, busy, res, rdo, err);
        n_checks++; if (res !== 32'hBEEF0000) begin n_fails++; $display("FAIL sh_readback: got %h want beef0000", res); end
        run_op(mk(3'b010, OP_STORE), 32'd12, 32'h0BADF00D, 5'd1, lat, busy, res, rdo, err);
        run_op(mk(3'b001, OP_LOAD), 32'd12, 32'h0, 5'd1, lat, busy, res, rdo, err);
        n_checks++; if (res !== 32'hFFFFF00D) begin n_fails++; $display("FAIL sw_then_lh: got %h want fffff00d", res); end
    endtask

    task automatic test_errors;
        int lat, busy; logic [31:0] res; logic [4:0] rdo; logic err;
        init_word(4'd0, 32'hCAFEF00D);
        init_word(4'd1, 32'h01020304);
        run_op(mk(3'b010, OP_LOAD), 32'd6, 32'h0, 5'd2, lat, busy, res, rdo, err);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        n_checks++; if (err !== 1'b1 || res !== 32'd0) begin n_fails++; $display("FAIL lw_misaligned: err %b res %h want 1 0", err, res); end
`else
        n_checks++; if (err !== 1'b0 || res !== 32'h01020304) begin n_fails++; $display("FAIL lw_misaligned: err %b res %h want 0 01020304", err, res); end
`endif
        run_op(mk(3'b010, OP_STORE), DEPTH * 4, 32'h11111111, 5'd2, lat, busy, res, rdo, err);
        n_checks++; if (err !== 1'b1 || res !== 32'd0) begin n_fails++; $display("FAIL sw_out_of_range: err %b res %h want 1 0", err, res); end
        run_op(mk(3'b000, OP_LOAD), 32'h100, 32'h0, 5'd2, lat, busy, res, rdo, err);
        n_checks++; if (err !== 1'b1 || res !== 32'd0) begin n_fails++; $display("FAIL lb_out_of_range: err %b res %h want 1 0", err, res); end
        run_op(mk(3'b011, OP_LOAD), 32'd0, 32'h0, 5'd2, lat, busy, res, rdo, err);
        n_checks++; if (err !== 1'b1 || res !== 32'd0) begin n_fails++; $display("FAIL load_bad_funct3: err %b res %h want 1 0", err, res); end
        run_op(mk(3'b011, OP_STORE), 32'd0, 32'h22222222, 5'd2, lat, busy, res, rdo, err);
        n_checks++; if (err !== 1'b1) begin n_fails++; $display("FAIL store_bad_funct3: err %b want 1", err); end
        run_op(mk(3'b010, OP_LOAD), 32'd0, 32'h0, 5'd2, lat, busy, res, rdo, err);
        n_checks++; if (res !== 32'hCAFEF00D || err !== 1'b0) begin n_fails++; $display("FAIL word0_untouched: got %h err %b want cafef00d 0", res, err); end
    endtask

    task automatic test_reset_abort;
        int lat, busy, pulses; logic [31:0] res; logic [4:0] rdo; logic err;
        init_word(4'd4, 32'h55AA55AA);
        @(negedge clk_100MHz);
        bus.instr_in = mk(3'b010, OP_STORE); bus.alu_result = 32'd16; bus.rs2_data = 32'h12345678;
        bus.rd_in = 5'd0; bus.in_valid = 1'b1;
        @(posedge clk_100MHz); #1;
        bus.in_valid = 1'b0;
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_100MHz); #1;
            if (bus.out_valid) pulses++;
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_100MHz); #1;
            if (bus.out_valid) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fails++; $display("FAIL abort_no_valid: got %0d pulses want 0", pulses); end
        run_op(mk(3'b010, OP_LOAD), 32'd16, 32'h0, 5'd1, lat, busy, res, rdo, err);
        n_checks++; if (res !== 32'h55AA55AA) begin n_fails++; $display("FAIL abort_no_write: got %h want 55aa55aa", res); end
    endtask

    task automatic test_collision;
        int lat, busy; logic [31:0] res; logic [4:0] rdo; logic err;
        @(negedge clk_100MHz);
        bus.instr_in = mk(3'b010, OP_STORE); bus.alu_result = 32'd20; bus.rs2_data = 32'hAAAAAAAA;
        bus.rd_in = 5'd0; bus.in_valid = 1'b1;
        @(posedge clk_100MHz); #1;
        bus.in_valid = 1'b0;
        @(posedge clk_100MHz);
        @(posedge clk_100MHz); #1;
        init_en = 1'b1; init_we = 1'b1; init_addr = 4'd5; init_data = 32'h5A5A5A5A;
        @(posedge clk_100MHz); #1;
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fails++; $display("FAIL inflight_completes: valid %b want 1", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fails++; $display("FAIL init_blocks_ready: got %b want 0", bus.in_ready); end
        init_en = 1'b0; init_we = 1'b0;
        run_op(mk(3'b010, OP_LOAD), 32'd20, 32'h0, 5'd1, lat, busy, res, rdo, err);
        n_checks++; if (res !== 32'h5A5A5A5A) begin n_fails++; $display("FAIL init_wins: got %h want 5a5a5a5a", res); end
    endtask

    task automatic test_init_block;
        int pulses;
        @(negedge clk_100MHz);
        init_en = 1'b1;
        bus.instr_in = mk(3'd0, OP_R); bus.alu_result = 32'h77; bus.rd_in = 5'd6; bus.in_valid = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_100MHz); #1;
            if (bus.out_valid) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fails++; $display("FAIL init_no_accept: got %0d pulses want 0", pulses); end
        init_en = 1'b0;
        @(posedge clk_100MHz); #1;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.result_out !== 32'h77) begin n_fails++; $display("FAIL accept_after_init: valid %b res %h want 1 00000077", bus.out_valid, bus.result_out); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.instr_in = '0; bus.alu_result = '0; bus.rs2_data = '0; bus.rd_in = '0;
        test_reset();
        test_alu();
        test_back_to_back();
        test_loads();
        test_stores();
        test_errors();
        test_reset_abort();
        test_collision();
        test_init_block();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
